dec_ram_sched: RTL

Iteration scheduler for the ping-pong hard-decision RAM (`DEC_RAM`) in the LDPC decoder. It owns the RAM's address, write-enable, chip-select and bank-select. It loads the channel decisions, then alternates between two phases each iteration: streaming the current bank to the check unit, and writing the updated decisions into the other bank. It swaps banks after every iteration and stops on convergence or when the iteration limit is reached.

---
 rtl/dec_ram_sched_if.sv | 27 ++
 rtl/dec_ram_sched.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dec_ram_sched_if.sv
// Handshake and DEC_RAM port bundle between the iteration scheduler and its environment.
// master is the scheduler side; slave is the decision source / check unit / RAM side.
interface dec_ram_sched_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_we;
    logic                  ram_cs;
    logic                  ram_rs;
    logic [DATA_WIDTH-1:0] ram_data_in;

    modport master (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, ram_address, ram_we, ram_cs, ram_rs, ram_data_in
    );

    modport slave (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, ram_address, ram_we, ram_cs, ram_rs, ram_data_in
    );
endinterface

// File: rtl/dec_ram_sched.sv
// Ping-pong DEC_RAM iteration scheduler: load, then READ/DRAIN/CHECK/WRITE per iteration,
// swapping banks after each WRITE until convergence, the iteration limit, or abort.
module dec_ram_sched #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int ITER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dec_ram_sched_if.master       bus,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] n_last,
    input  logic [ITER_WIDTH-1:0] max_iter,
    input  logic                  chk_valid,
    input  logic                  chk_pass,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [ITER_WIDTH-1:0] iter_cnt,
    output logic                  final_bank
);
    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, CHECK, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic                  cur_bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] n_last_q;
    logic [ITER_WIDTH-1:0] max_iter_q;
    logic                  conv_q;
    logic                  rd_valid_q;
    logic                  wr_ready;
    logic                  ram_cs;
    logic                  ram_rs;
    logic                  at_last;
    logic                  wr_hs;
    logic                  rd_issue;

    assign at_last  = (addr == n_last_q);
    assign wr_hs    = wr_ready & bus.wr_valid;
    assign rd_issue = (state == READ) & bus.rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        ram_cs    = 1'b0;
        ram_rs    = cur_bank;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD: begin
                wr_ready = 1'b1;
                ram_cs   = 1'b1;
                if (bus.wr_valid && at_last) state_nxt = READ;
            end
            READ: begin
                ram_cs = 1'b1;
                if (bus.rd_ready && at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                ram_cs    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                ram_cs = 1'b1;
                if (chk_valid) begin
                    if (chk_pass || (iter_cnt == max_iter_q)) state_nxt = DONE;
                    else                                     state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                ram_cs   = 1'b1;
                ram_rs   = ~cur_bank;
                if (bus.wr_valid && at_last) state_nxt = READ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bank   <= 1'b0;
            addr       <= '0;
            iter_cnt   <= '0;
            n_last_q   <= '0;
            max_iter_q <= '0;
            conv_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_issue & ~abort;
            if (state == IDLE) begin
                if (start) begin
                    cur_bank   <= 1'b0;
                    addr       <= '0;
                    iter_cnt   <= '0;
                    conv_q     <= 1'b0;
                    n_last_q   <= n_last;
                    max_iter_q <= max_iter;
                end
            end else if (abort) begin
                addr <= '0;
            end else begin
                if (wr_hs || rd_issue) addr <= at_last ? '0 : addr + 1'b1;
                // Bank swap and iteration count happen together on the last WRITE handshake.
                if ((state == WRITE) && wr_hs && at_last) begin
                    cur_bank <= ~cur_bank;
                    iter_cnt <= iter_cnt + 1'b1;
                end
                if ((state == CHECK) && chk_valid) conv_q <= chk_pass;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE) & ~abort;
    assign converged  = done & conv_q;
    assign final_bank = cur_bank;

    assign bus.wr_ready    = wr_ready;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.ram_address = addr;
    assign bus.ram_we      = wr_hs;
    assign bus.ram_cs      = ram_cs;
    assign bus.ram_rs      = ram_rs;
    assign bus.ram_data_in = bus.wr_data;
endmodule
